// File: rtl/cpu_subsys_bridge_pkg.sv
// Shared types and constants for the CPU subsystem memory bridge.
//   bridge_state_e    : bridge FSM state encoding
//   ERR_RDATA_DEFAULT : read data returned on an error response
//   MAX_TARGETS       : upper bound on the number of downstream targets
//   tgt_idx_t         : index wide enough to address MAX_TARGETS targets
package cpu_subsys_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RESP   = 2'd2,
    ERR    = 2'd3
  } bridge_state_e;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;
  localparam int          MAX_TARGETS       = 8;

  typedef logic [$clog2(MAX_TARGETS)-1:0] tgt_idx_t;

endpackage

// File: rtl/cpu_subsys_addr_decode.sv
// Combinational base/mask address decoder.
// Target i hits when (addr & TGT_MASK[32*i +: 32]) == TGT_BASE[32*i +: 32].
// When several targets hit, the lowest index is reported.
// Ports:
//   addr    in  32  address to decode
//   hit     out 1   at least one target matched
//   tgt_idx out     index of the winning target (0 when no hit)
module cpu_subsys_addr_decode
  import cpu_subsys_bridge_pkg::*;
#(
  parameter int                        NUM_TARGETS = 3,
  parameter logic [NUM_TARGETS*32-1:0] TGT_BASE    = {32'h8000_0000, 32'h4000_0000, 32'h0000_0000},
  parameter logic [NUM_TARGETS*32-1:0] TGT_MASK    = {32'h8000_0000, 32'hC000_0000, 32'hC000_0000}
) (
  input  logic [31:0] addr,
  output logic        hit,
  output tgt_idx_t    tgt_idx
);

  // Walk from the highest index down so the lowest matching index is the
  // last assignment and therefore wins.
  always_comb begin
    hit     = 1'b0;
    tgt_idx = '0;
    for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
      if ((addr & TGT_MASK[32*i +: 32]) == TGT_BASE[32*i +: 32]) begin
        hit     = 1'b1;
        tgt_idx = tgt_idx_t'(i);
      end
    end
  end

endmodule

// File: rtl/cpu_subsys_mem_bridge.sv
// CPU native memory interface to NUM_TARGETS memory-mapped targets.
// Requests are latched on acceptance so target-facing signals stay stable for
// the whole transaction. Unmapped accesses return an error response.
// Optional macro CPU_SUBSYS_BRIDGE_TIMEOUT_EN adds a per-transaction timeout
// that turns a stuck target into an error response.
//
// state  | meaning
// IDLE   | waiting for cpu_mem_valid; decode and latch the request
// ACTIVE | tgt_mem_valid asserted to the selected target, waiting for ready
// RESP   | one-cycle cpu_mem_ready with the captured target read data
// ERR    | one-cycle cpu_mem_ready + bus_err with ERR_RDATA
//
// Ports:
//   sys_clk, rst_n              clock, async active-low reset
//   cpu_mem_*                   CPU request (valid/addr/wdata/we/be) and response (ready/rdata)
//   tgt_mem_valid/ready         per-target handshake
//   tgt_mem_addr/wdata/wstrb    registered request broadcast to all targets
//   tgt_mem_rdata               per-target read data, slice [32*i +: 32]
//   bus_err                     pulse with an error response
//   err_addr                    address of the most recent errored access
module cpu_subsys_mem_bridge
  import cpu_subsys_bridge_pkg::*;
#(
  parameter int                        NUM_TARGETS    = 3,
  parameter logic [NUM_TARGETS*32-1:0] TGT_BASE       = {32'h8000_0000, 32'h4000_0000, 32'h0000_0000},
  parameter logic [NUM_TARGETS*32-1:0] TGT_MASK       = {32'h8000_0000, 32'hC000_0000, 32'hC000_0000},
  parameter int                        TIMEOUT_CYCLES = 1024,
  parameter logic [31:0]               ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic                      sys_clk,
  input  logic                      rst_n,
  input  logic                      cpu_mem_valid,
  output logic                      cpu_mem_ready,
  input  logic [31:0]               cpu_mem_addr,
  input  logic [31:0]               cpu_mem_wdata,
  input  logic                      cpu_mem_we,
  input  logic [3:0]                cpu_mem_be,
  output logic [31:0]               cpu_mem_rdata,
  output logic [NUM_TARGETS-1:0]    tgt_mem_valid,
  input  logic [NUM_TARGETS-1:0]    tgt_mem_ready,
  output logic [31:0]               tgt_mem_addr,
  output logic [31:0]               tgt_mem_wdata,
  output logic [3:0]                tgt_mem_wstrb,
  input  logic [NUM_TARGETS*32-1:0] tgt_mem_rdata,
  output logic                      bus_err,
  output logic [31:0]               err_addr
);

  if (NUM_TARGETS < 1 || NUM_TARGETS > MAX_TARGETS) begin : g_bad_num_targets
    $error("NUM_TARGETS must be 1..8");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be 2..65535");
  end

  bridge_state_e          state_q, state_d;
  tgt_idx_t               sel_q, sel_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [3:0]             wstrb_q, wstrb_d;
  logic [NUM_TARGETS-1:0] tgt_valid_q, tgt_valid_d;
  logic                   cpu_ready_q, cpu_ready_d;
  logic [31:0]            cpu_rdata_q, cpu_rdata_d;
  logic                   bus_err_q, bus_err_d;
  logic [31:0]            err_addr_q, err_addr_d;

  logic                   dec_hit;
  tgt_idx_t               dec_idx;
  logic                   sel_ready;
  logic [31:0]            sel_rdata;

`ifdef CPU_SUBSYS_BRIDGE_TIMEOUT_EN
  localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0]            cnt_q, cnt_d;
`endif

  cpu_subsys_addr_decode #(
    .NUM_TARGETS (NUM_TARGETS),
    .TGT_BASE    (TGT_BASE),
    .TGT_MASK    (TGT_MASK)
  ) u_decode (
    .addr    (cpu_mem_addr),
    .hit     (dec_hit),
    .tgt_idx (dec_idx)
  );

  // tgt_valid_q is one-hot on sel_q in ACTIVE, so masking ready with it
  // ignores every non-selected target.
  always_comb begin
    sel_ready = |(tgt_mem_ready & tgt_valid_q);
    sel_rdata = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (sel_q == tgt_idx_t'(i)) sel_rdata = tgt_mem_rdata[32*i +: 32];
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    tgt_valid_d = tgt_valid_q;
    cpu_ready_d = 1'b0;
    cpu_rdata_d = '0;
    bus_err_d   = 1'b0;
    err_addr_d  = err_addr_q;
`ifdef CPU_SUBSYS_BRIDGE_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (cpu_mem_valid) begin
          if (dec_hit) begin
            sel_d   = dec_idx;
            addr_d  = cpu_mem_addr;
            wdata_d = cpu_mem_wdata;
            wstrb_d = cpu_mem_we ? cpu_mem_be : 4'b0000;
            for (int i = 0; i < NUM_TARGETS; i++) begin
              tgt_valid_d[i] = (dec_idx == tgt_idx_t'(i));
            end
`ifdef CPU_SUBSYS_BRIDGE_TIMEOUT_EN
            cnt_d   = '0;
`endif
            state_d = ACTIVE;
          end else begin
            err_addr_d  = cpu_mem_addr;
            cpu_ready_d = 1'b1;
            bus_err_d   = 1'b1;
            cpu_rdata_d = ERR_RDATA;
            state_d     = ERR;
          end
        end
      end
      ACTIVE: begin
        // Ready wins over a timeout landing in the same cycle.
        if (sel_ready) begin
          tgt_valid_d = '0;
          cpu_ready_d = 1'b1;
          cpu_rdata_d = sel_rdata;
          state_d     = RESP;
        end
`ifdef CPU_SUBSYS_BRIDGE_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          tgt_valid_d = '0;
          err_addr_d  = addr_q;
          cpu_ready_d = 1'b1;
          bus_err_d   = 1'b1;
          cpu_rdata_d = ERR_RDATA;
          state_d     = ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      tgt_valid_q <= '0;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      bus_err_q   <= 1'b0;
      err_addr_q  <= '0;
`ifdef CPU_SUBSYS_BRIDGE_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      tgt_valid_q <= tgt_valid_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      bus_err_q   <= bus_err_d;
      err_addr_q  <= err_addr_d;
`ifdef CPU_SUBSYS_BRIDGE_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign cpu_mem_ready = cpu_ready_q;
  assign cpu_mem_rdata = cpu_rdata_q;
  assign tgt_mem_valid = tgt_valid_q;
  assign tgt_mem_addr  = addr_q;
  assign tgt_mem_wdata = wdata_q;
  assign tgt_mem_wstrb = wstrb_q;
  assign bus_err       = bus_err_q;
  assign err_addr      = err_addr_q;

endmodule

// File: tb/tb_cpu_subsys_mem_bridge.sv
// Directed bench for cpu_subsys_mem_bridge. Two instances share stimulus:
// dut_a uses the default address map, dut_b a map with an overlap
// (targets 0 and 1 both cover 0x4xxx_xxxx) and a hole at 0xC000_0000.
// use_b selects which instance sees valid/ready and which one is checked.
module tb_cpu_subsys_mem_bridge;

  logic sys_clk;
  logic rst_n;
  logic use_b;

  logic        cpu_valid;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_we;
  logic [3:0]  cpu_be;
  logic [2:0]  tgt_ready;
  logic [95:0] tgt_rdata;

  logic        a_valid_in, b_valid_in;
  logic [2:0]  a_tready, b_tready;
  logic        a_ready, b_ready, a_berr, b_berr;
  logic [31:0] a_rdata, b_rdata, a_taddr, b_taddr, a_twdata, b_twdata, a_eaddr, b_eaddr;
  logic [2:0]  a_tvalid, b_tvalid;
  logic [3:0]  a_wstrb, b_wstrb;

  logic        ready, berr;
  logic [31:0] rdata, taddr, twdata, eaddr;
  logic [2:0]  tvalid;
  logic [3:0]  wstrb;

  int n_chk = 0;
  int n_err = 0;

  assign a_valid_in = cpu_valid & ~use_b;
  assign b_valid_in = cpu_valid & use_b;
  assign a_tready   = tgt_ready & {3{~use_b}};
  assign b_tready   = tgt_ready & {3{use_b}};

  assign ready  = use_b ? b_ready  : a_ready;
  assign berr   = use_b ? b_berr   : a_berr;
  assign rdata  = use_b ? b_rdata  : a_rdata;
  assign taddr  = use_b ? b_taddr  : a_taddr;
  assign twdata = use_b ? b_twdata : a_twdata;
  assign eaddr  = use_b ? b_eaddr  : a_eaddr;
  assign tvalid = use_b ? b_tvalid : a_tvalid;
  assign wstrb  = use_b ? b_wstrb  : a_wstrb;

  cpu_subsys_mem_bridge #(
    .TIMEOUT_CYCLES (16)
  ) dut_a (
    .sys_clk       (sys_clk),
    .rst_n         (rst_n),
    .cpu_mem_valid (a_valid_in),
    .cpu_mem_ready (a_ready),
    .cpu_mem_addr  (cpu_addr),
    .cpu_mem_wdata (cpu_wdata),
    .cpu_mem_we    (cpu_we),
    .cpu_mem_be    (cpu_be),
    .cpu_mem_rdata (a_rdata),
    .tgt_mem_valid (a_tvalid),
    .tgt_mem_ready (a_tready),
    .tgt_mem_addr  (a_taddr),
    .tgt_mem_wdata (a_twdata),
    .tgt_mem_wstrb (a_wstrb),
    .tgt_mem_rdata (tgt_rdata),
    .bus_err       (a_berr),
    .err_addr      (a_eaddr)
  );

  cpu_subsys_mem_bridge #(
    .TGT_MASK ({32'hC000_0000, 32'hC000_0000, 32'h8000_0000})
  ) dut_b (
    .sys_clk       (sys_clk),
    .rst_n         (rst_n),
    .cpu_mem_valid (b_valid_in),
    .cpu_mem_ready (b_ready),
    .cpu_mem_addr  (cpu_addr),
    .cpu_mem_wdata (cpu_wdata),
    .cpu_mem_we    (cpu_we),
    .cpu_mem_be    (cpu_be),
    .cpu_mem_rdata (b_rdata),
    .tgt_mem_valid (b_tvalid),
    .tgt_mem_ready (b_tready),
    .tgt_mem_addr  (b_taddr),
    .tgt_mem_wdata (b_twdata),
    .tgt_mem_wstrb (b_wstrb),
    .tgt_mem_rdata (tgt_rdata),
    .bus_err       (b_berr),
    .err_addr      (b_eaddr)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  // One CPU access. waits = ACTIVE cycles before the selected target raises
  // ready; while waiting the other targets assert ready, which must be ignored.
  // exp_tv is the expected tgt_mem_valid in ACTIVE, exp_lat the cycle count
  // from the request cycle to the cpu_mem_ready cycle.
  task automatic access(input string tag, input logic [31:0] addr, input logic we,
                        input logic [3:0] be, input logic [31:0] wdata, input int waits,
                        input logic [31:0] rd, input logic [2:0] exp_tv,
                        input logic exp_err, input int exp_lat);
    int          lat = 0;
    int          act = 0;
    logic        done = 1'b0;
    logic [31:0] exp_rd;
    exp_rd    = exp_err ? 32'hDEAD_BEEF : rd;
    cpu_valid = 1'b1;
    cpu_addr  = addr;
    cpu_we    = we;
    cpu_be    = be;
    cpu_wdata = wdata;
    tgt_ready = 3'b000;
    tgt_rdata = {3{32'h0BAD_0BAD}};
    for (int i = 0; i < 3; i++) if (exp_tv[i]) tgt_rdata[32*i +: 32] = rd;
    while (!done && lat < 40) begin
      tick;
      lat++;
      if (ready) begin
        done = 1'b1;
      end else begin
        act++;
        chk({tag, " tvalid"}, 64'(tvalid), 64'(exp_tv));
        chk({tag, " taddr"}, 64'(taddr), 64'(addr));
        chk({tag, " twdata"}, 64'(twdata), 64'(wdata));
        chk({tag, " wstrb"}, 64'(wstrb), 64'(we ? be : 4'b0000));
        cpu_addr  = ~addr;
        cpu_wdata = ~wdata;
        cpu_we    = ~we;
        tgt_ready = (act == waits + 1) ? exp_tv : (~exp_tv & 3'b111);
      end
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " rdata"}, 64'(rdata), 64'(exp_rd));
    chk({tag, " bus_err"}, 64'(berr), 64'(exp_err));
    chk({tag, " tvalid_resp"}, 64'(tvalid), 64'd0);
    cpu_valid = 1'b0;
    tgt_ready = 3'b000;
    tick;
    chk({tag, " idle_after"}, {31'd0, ready, rdata}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    use_b     = 1'b0;
    cpu_valid = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    cpu_we    = 1'b0;
    cpu_be    = 4'h0;
    tgt_ready = 3'b000;
    tgt_rdata = '0;
    repeat (2) @(posedge sys_clk);
    #1;
    chk("reset ctl", {23'd0, ready, berr, tvalid, wstrb, rdata}, 64'd0);
    chk("reset addr", {taddr, eaddr}, 64'd0);
    chk("reset wdata", 64'(twdata), 64'd0);
    rst_n = 1'b1;
    tick;

    access("rd_t1", 32'h4000_0010, 1'b0, 4'hF, 32'h0, 0, 32'h1234_5678, 3'b010, 1'b0, 2);
    access("wr_t2", 32'h8000_0004, 1'b1, 4'b0011, 32'hA5A5_A5A5, 5, 32'h5A5A_0001, 3'b100, 1'b0, 7);
    access("b2b_t0", 32'h0000_0100, 1'b0, 4'hF, 32'h0, 1, 32'hCAFE_0001, 3'b001, 1'b0, 3);
    chk("a err_addr clean", 64'(eaddr), 64'd0);

    use_b = 1'b1;
    access("overlap", 32'h4000_0000, 1'b0, 4'hF, 32'h0, 0, 32'h1111_2222, 3'b001, 1'b0, 2);
    access("unmapped_wr", 32'hC000_0000, 1'b1, 4'hF, 32'h0000_1234, 0, 32'h0, 3'b000, 1'b1, 1);
    chk("err_addr c0", 64'(eaddr), 64'h0000_0000_C000_0000);
    access("b_t2", 32'h8000_0010, 1'b0, 4'hF, 32'h0, 2, 32'h2468_ACE0, 3'b100, 1'b0, 4);
    chk("err_addr hold", 64'(eaddr), 64'h0000_0000_C000_0000);
    access("unmapped_rd", 32'hF000_0004, 1'b0, 4'hF, 32'h0, 0, 32'h0, 3'b000, 1'b1, 1);
    chk("err_addr f0", 64'(eaddr), 64'h0000_0000_F000_0004);

    use_b = 1'b0;
`ifdef CPU_SUBSYS_BRIDGE_TIMEOUT_EN
    access("timeout", 32'h8000_0040, 1'b0, 4'hF, 32'h0, 1000, 32'h0, 3'b100, 1'b1, 17);
    chk("timeout err_addr", 64'(eaddr), 64'h0000_0000_8000_0040);
    tgt_ready = 3'b100;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("late ready", {60'd0, ready, tvalid}, 64'd0);
    end
    tgt_ready = 3'b000;
    access("to_edge", 32'h8000_0044, 1'b0, 4'hF, 32'h0, 15, 32'h7777_8888, 3'b100, 1'b0, 17);
    access("after_to", 32'h4000_0004, 1'b0, 4'hF, 32'h0, 0, 32'h0F0F_0F0F, 3'b010, 1'b0, 2);
`else
    access("long_wait", 32'h8000_0040, 1'b0, 4'hF, 32'h0, 30, 32'h7777_8888, 3'b100, 1'b0, 32);
`endif

    cpu_valid = 1'b1;
    cpu_addr  = 32'h4000_0020;
    cpu_we    = 1'b0;
    cpu_be    = 4'hF;
    tick;
    chk("pre_rst tvalid", 64'(tvalid), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst async tvalid", 64'(tvalid), 64'd0);
    cpu_valid = 1'b0;
    tgt_ready = 3'b010;
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("rst no ready", {60'd0, ready, tvalid}, 64'd0);
    end
    rst_n     = 1'b1;
    tgt_ready = 3'b000;
    tick;
    chk("post_rst idle", {31'd0, ready, eaddr}, 64'd0);
    access("post_rst", 32'h0000_0200, 1'b0, 4'hF, 32'h0, 2, 32'h3C3C_3C3C, 3'b001, 1'b0, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
